array_seq_ctrl: RTL and testbench

ARRAY_SEQ_CTRL -- requirements
Module: array_seq_ctrl

---
 rtl/array_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_array_seq_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/array_seq_ctrl.sv
// array_seq_ctrl: sequences one kernel-load + execute pass of a row x col MAC array.
// Ports: clk, reset (sync, active-high), start, num_act -> inst_w, l0_rd, busy, done.
module array_seq_ctrl #(
    parameter int row   = 8,
    parameter int col   = 8,
    parameter int len_w = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [len_w-1:0] num_act,
    output logic [1:0]       inst_w,
    output logic [row-1:0]   l0_rd,
    output logic             busy,
    output logic             done
);

    localparam int RC_W = $clog2(row + col);
    localparam int CW   = (len_w > RC_W) ? len_w : RC_W;

    localparam logic [CW-1:0] LOAD_LAST  = CW'(col - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(row + col - 2);
    localparam logic [CW-1:0] ONE        = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        EXEC,
        DRAIN,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [len_w-1:0] act_q, act_n;

    logic [1:0] inst_n;
    logic       base_n;
    logic       busy_n;
    logic       done_n;

    // Counter holds the remaining cycles minus one in the current state;
    // it is reloaded on each transition so long EXEC counts never wrap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        act_n   = act_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    cnt_n   = LOAD_LAST;
                    act_n   = num_act;
                end
            end
            LOAD: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            GAP: begin
                if (act_q == '0) begin
                    state_n = DRAIN;
                    cnt_n   = DRAIN_LAST;
                end else begin
                    state_n = EXEC;
                    cnt_n   = CW'(act_q) - ONE;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_n = DRAIN;
                    cnt_n   = DRAIN_LAST;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values
    // line up with the state they describe.
    always_comb begin
        inst_n = 2'b00;
        base_n = 1'b0;
        busy_n = 1'b1;
        done_n = 1'b0;
        unique case (state_n)
            IDLE:  busy_n = 1'b0;
            LOAD: begin
                inst_n = 2'b01;
                base_n = 1'b1;
            end
            GAP:   inst_n = 2'b00;
            EXEC: begin
                inst_n = 2'b10;
                base_n = 1'b1;
            end
            DRAIN: inst_n = 2'b00;
            DONE:  done_n = 1'b1;
            default: busy_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            act_q  <= '0;
            inst_w <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b0;
            l0_rd  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            act_q  <= act_n;
            inst_w <= inst_n;
            busy   <= busy_n;
            done   <= done_n;
            // Lane r sees the base strobe r cycles late.
            l0_rd[0] <= base_n;
            for (int r = 1; r < row; r++) begin
                l0_rd[r] <= l0_rd[r-1];
            end
        end
    end

endmodule

// File: tb/tb_array_seq_ctrl.sv
// tb_array_seq_ctrl: directed self-checking bench for array_seq_ctrl
// (row=8, col=8, len_w=8).
module tb_array_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] num_act;
    logic [1:0] inst_w;
    logic [7:0] l0_rd;
    logic       busy;
    logic       done;

    int n_asserts = 0;
    int n_fails   = 0;

    array_seq_ctrl #(.row(8), .col(8), .len_w(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .num_act (num_act),
        .inst_w  (inst_w),
        .l0_rd   (l0_rd),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_asserts++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Base strobe of a pass begun at edge 0: LOAD cycles 1-8, EXEC 10..9+n.
    function automatic logic base_at(input int c, input int n);
        return (c >= 1 && c <= 8) || (c >= 10 && c <= 9 + n);
    endfunction

    function automatic logic [1:0] inst_at(input int c, input int n);
        if (c >= 1 && c <= 8) return 2'b01;
        if (c >= 10 && c <= 9 + n) return 2'b10;
        return 2'b00;
    endfunction

    // One full pass; optionally pulse start (num_act=9) in EXEC and in DONE.
    task automatic run_pass(input int n, input bit poke);
        int d;
        int lane_cnt [8];
        logic [7:0] exp_rd;
        d = 25 + n;
        for (int r = 0; r < 8; r++) lane_cnt[r] = 0;
        start   = 1'b1;
        num_act = 8'(n);
        tick();
        start   = 1'b0;
        num_act = 8'd0;
        for (int c = 1; c <= d; c++) begin
            for (int r = 0; r < 8; r++) begin
                exp_rd[r] = base_at(c - r, n);
                if (l0_rd[r]) lane_cnt[r]++;
            end
            chk($sformatf("inst_w n=%0d c=%0d", n, c), 32'(inst_w), 32'(inst_at(c, n)));
            chk($sformatf("l0_rd n=%0d c=%0d", n, c), 32'(l0_rd), 32'(exp_rd));
            chk($sformatf("busy n=%0d c=%0d", n, c), 32'(busy), 32'd1);
            chk($sformatf("done n=%0d c=%0d", n, c), 32'(done), 32'(c == d));
            if (poke && (c == 11 || c == d)) begin
                start   = 1'b1;
                num_act = 8'd9;
            end else begin
                start   = 1'b0;
                num_act = 8'd0;
            end
            tick();
        end
        start   = 1'b0;
        num_act = 8'd0;
        chk($sformatf("idle busy n=%0d", n), 32'(busy), 32'd0);
        chk($sformatf("idle done n=%0d", n), 32'(done), 32'd0);
        chk($sformatf("idle inst n=%0d", n), 32'(inst_w), 32'd0);
        chk($sformatf("idle l0_rd n=%0d", n), 32'(l0_rd), 32'd0);
        for (int r = 0; r < 8; r++)
            chk($sformatf("lane%0d total n=%0d", r, n), 32'(lane_cnt[r]), 32'(8 + n));
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        num_act = 8'd0;
        tick();
        tick();
        chk("rst inst_w", 32'(inst_w), 32'd0);
        chk("rst l0_rd", 32'(l0_rd), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);

        // Reset wins over start in the same cycle.
        start   = 1'b1;
        num_act = 8'd4;
        tick();
        chk("rst prio busy", 32'(busy), 32'd0);
        chk("rst prio inst", 32'(inst_w), 32'd0);
        reset   = 1'b0;
        start   = 1'b0;
        num_act = 8'd0;
        tick();
        chk("idle stays busy", 32'(busy), 32'd0);

        run_pass(4, 1'b0);
        run_pass(0, 1'b0);
        run_pass(4, 1'b1);
        // Start in the IDLE cycle right after DONE is accepted.
        run_pass(4, 1'b0);

        // Abort mid-EXEC: reset sampled at edge 11.
        start   = 1'b1;
        num_act = 8'd4;
        tick();
        start   = 1'b0;
        num_act = 8'd0;
        for (int c = 1; c < 11; c++) tick();
        chk("pre-abort inst", 32'(inst_w), 32'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort inst", 32'(inst_w), 32'd0);
        chk("abort l0_rd", 32'(l0_rd), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("post-abort done c=%0d", c), 32'(done), 32'd0);
            chk($sformatf("post-abort busy c=%0d", c), 32'(busy), 32'd0);
        end
        run_pass(4, 1'b0);

        run_pass(255, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule
